// File: rtl/flash_led_ctrl.sv
// Flash-LED sequencer: debounced switch popcount selects the step rate, and the
// step tick (CLK_BPS) drives a walk-left / walk-right / blink LED pattern.
module flash_led_ctrl #(
    parameter int unsigned BASE_DIV     = 50_000_000,
    parameter int unsigned DEBOUNCE_CYC = 1_000_000,
    parameter int unsigned BLINK_TICKS  = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  switch,
    output logic [15:0] led,
    output logic        CLK_BPS,
    output logic [3:0]  level
);

    localparam int unsigned DB_W  = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
    localparam int unsigned DIV_W = (BASE_DIV > 1) ? $clog2(BASE_DIV + 1) : 1;
    localparam int unsigned BC_W  = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;

    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYC - 1);
    localparam logic [BC_W-1:0] BC_LAST = BC_W'(BLINK_TICKS - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SHL,
        ST_SHR,
        ST_BLINK
    } state_t;

    state_t            state_q, state_d;
    logic [7:0]        sync1_q, sync1_d;
    logic [7:0]        sw_s_q, sw_s_d;
    logic [7:0]        sw_db_q, sw_db_d;
    logic [DB_W-1:0]   db_cnt_q, db_cnt_d;
    logic [3:0]        level_q, level_d;
    logic              chg_q, chg_d;
    logic [DIV_W-1:0]  cnt_q, cnt_d;
    logic              bps_q, bps_d;
    logic [15:0]       led_q, led_d;
    logic [BC_W-1:0]   bcnt_q, bcnt_d;

    logic              lvl_chg_c;
    logic [31:0]       div_shift_c;
    logic [DIV_W-1:0]  period_c;
    logic [DIV_W-1:0]  period_last_c;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= ST_IDLE;
            sync1_q  <= '0;
            sw_s_q   <= '0;
            sw_db_q  <= '0;
            db_cnt_q <= '0;
            level_q  <= '0;
            chg_q    <= 1'b0;
            cnt_q    <= '0;
            bps_q    <= 1'b0;
            led_q    <= '0;
            bcnt_q   <= '0;
        end else begin
            state_q  <= state_d;
            sync1_q  <= sync1_d;
            sw_s_q   <= sw_s_d;
            sw_db_q  <= sw_db_d;
            db_cnt_q <= db_cnt_d;
            level_q  <= level_d;
            chg_q    <= chg_d;
            cnt_q    <= cnt_d;
            bps_q    <= bps_d;
            led_q    <= led_d;
            bcnt_q   <= bcnt_d;
        end
    end

    // Synchroniser, debounce and level; the stable count restarts whenever the
    // synchronised value is about to change (first stage differs from second).
    always_comb begin
        sync1_d  = switch;
        sw_s_d   = sync1_q;
        sw_db_d  = sw_db_q;
        db_cnt_d = db_cnt_q;
        level_d  = '0;

        if (sync1_q != sw_s_q) begin
            db_cnt_d = '0;
        end else if (db_cnt_q != DB_LAST) begin
            db_cnt_d = db_cnt_q + DB_W'(1);
        end

        if ((sw_s_q != sw_db_q) && (db_cnt_q == DB_LAST)) begin
            sw_db_d = sw_s_q;
        end

        for (int i = 0; i < 8; i++) begin
            level_d = level_d + 4'(sw_db_q[i]);
        end
    end

    // Tick divider: a level update suppresses the tick on its own cycle and the
    // count restarts from 0 on the following cycle.
    always_comb begin
        lvl_chg_c     = (level_d != level_q);
        chg_d         = lvl_chg_c;
        div_shift_c   = 32'(BASE_DIV) >> level_q;
        period_c      = (div_shift_c == 32'd0) ? DIV_W'(1) : DIV_W'(div_shift_c);
        period_last_c = period_c - DIV_W'(1);
        cnt_d         = '0;

        if (lvl_chg_c || chg_q || (level_q == 4'd0)) begin
            cnt_d = '0;
        end else if (cnt_q == period_last_c) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + DIV_W'(1);
        end

        bps_d = !lvl_chg_c && (level_q != 4'd0) && (cnt_d == period_last_c);
    end

    // Pattern FSM; all stepping is gated by the registered tick.
    always_comb begin
        state_d = state_q;
        led_d   = led_q;
        bcnt_d  = bcnt_q;

        case (state_q)
            ST_IDLE: begin
                led_d = '0;
                if (level_q != 4'd0) begin
                    state_d = ST_SHL;
                    led_d   = 16'h0001;
                end
            end
            ST_SHL: begin
                if (bps_q) begin
                    if (led_q == 16'h8000) begin
                        state_d = ST_SHR;
                        led_d   = 16'h4000;
                    end else begin
                        led_d = led_q << 1;
                    end
                end
            end
            ST_SHR: begin
                if (bps_q) begin
                    if (led_q == 16'h0001) begin
                        state_d = ST_BLINK;
                        led_d   = 16'hFFFF;
                        bcnt_d  = '0;
                    end else begin
                        led_d = led_q >> 1;
                    end
                end
            end
            ST_BLINK: begin
                if (bps_q) begin
                    if (bcnt_q == BC_LAST) begin
                        state_d = ST_SHL;
                        led_d   = 16'h0001;
                    end else begin
                        led_d  = ~led_q;
                        bcnt_d = bcnt_q + BC_W'(1);
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                led_d   = '0;
            end
        endcase
    end

    assign led     = led_q;
    assign CLK_BPS = bps_q;
    assign level   = level_q;

endmodule

// File: tb/tb_flash_led_ctrl.sv
// Directed bench for flash_led_ctrl with small divider/debounce parameters.
module tb_flash_led_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  switch;
    logic [15:0] led;
    logic        CLK_BPS;
    logic [3:0]  level;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        logic [7:0] sw;
        logic [3:0] exp_level;
        int         exp_period;
    } lvl_vec_t;

    lvl_vec_t    lvl_tab [7];
    logic [15:0] walk_led [34];

    flash_led_ctrl #(
        .BASE_DIV    (256),
        .DEBOUNCE_CYC(4),
        .BLINK_TICKS (4)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .switch (switch),
        .led    (led),
        .CLK_BPS(CLK_BPS),
        .level  (level)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Steps until CLK_BPS is seen high or the limit expires; n = cycles taken.
    task automatic wait_tick(input int limit, output int n);
        n = 0;
        do begin
            step();
            n++;
        end while ((CLK_BPS !== 1'b1) && (n < limit));
    endtask

    // Switch-on from IDLE with switch=1F: level 5 at cycle 7, walk starts next cycle.
    task automatic run_start(input string tag);
        int n;
        switch = 8'h1F;
        repeat (6) step();
        check({tag, "_level_pre"}, 32'(level), 32'd0);
        step();
        check({tag, "_level"}, 32'(level), 32'd5);
        check({tag, "_led_idle"}, 32'(led), 32'h0000);
        check({tag, "_bps_upd"}, 32'(CLK_BPS), 32'd0);
        step();
        check({tag, "_led_first"}, 32'(led), 32'h0001);
        wait_tick(40, n);
        check({tag, "_first_tick"}, 32'(n), 32'd7);
        step();
        check({tag, "_led_step"}, 32'(led), 32'h0002);
    endtask

    initial begin
        int       n;
        int       bad;
        logic [15:0] hold;
        logic [15:0] prev;
        bit       found;

        lvl_tab = '{
            '{8'h01, 4'd1, 128},
            '{8'h03, 4'd2, 64},
            '{8'h0F, 4'd4, 16},
            '{8'h5B, 4'd5, 8},
            '{8'h7F, 4'd7, 2},
            '{8'hFF, 4'd8, 1},
            '{8'h00, 4'd0, 0}
        };
        walk_led = '{
            16'h0004, 16'h0008, 16'h0010, 16'h0020, 16'h0040, 16'h0080, 16'h0100,
            16'h0200, 16'h0400, 16'h0800, 16'h1000, 16'h2000, 16'h4000, 16'h8000,
            16'h4000, 16'h2000, 16'h1000, 16'h0800, 16'h0400, 16'h0200, 16'h0100,
            16'h0080, 16'h0040, 16'h0020, 16'h0010, 16'h0008, 16'h0004, 16'h0002,
            16'h0001,
            16'hFFFF, 16'h0000, 16'hFFFF, 16'h0000, 16'h0001
        };

        // Reset hold
        rst    = 1'b0;
        switch = 8'h00;
        repeat (5) begin
            step();
            check("rst_led", 32'(led), 32'h0000);
            check("rst_bps", 32'(CLK_BPS), 32'd0);
            check("rst_level", 32'(level), 32'd0);
        end
        rst = 1'b1;
        repeat (2) step();

        run_start("s1");

        // Full loop: 34 more ticks, 8-cycle period
        for (int i = 0; i < 34; i++) begin
            wait_tick(40, n);
            check($sformatf("s2_gap_%0d", i), 32'(n), 32'd7);
            step();
            check($sformatf("s2_led_%0d", i), 32'(led), 32'(walk_led[i]));
        end

        // Pause: level change lands on a would-be tick and wins
        switch = 8'h00;
        repeat (6) step();
        check("s3_level_pre", 32'(level), 32'd5);
        step();
        check("s3_level0", 32'(level), 32'd0);
        check("s3_bps_supp", 32'(CLK_BPS), 32'd0);
        check("s3_led_held", 32'(led), 32'h0001);
        bad  = 0;
        hold = led;
        repeat (1000) begin
            step();
            if (CLK_BPS !== 1'b0 || led !== hold) bad++;
        end
        check("s3_pause_quiet", 32'(bad), 32'd0);
        switch = 8'h07;
        repeat (7) step();
        check("s3_level3", 32'(level), 32'd3);
        check("s3_bps_upd", 32'(CLK_BPS), 32'd0);
        wait_tick(100, n);
        check("s3_first_tick", 32'(n), 32'd32);
        step();
        check("s3_resume_led", 32'(led), 32'h0002);
        wait_tick(100, n);
        check("s3_gap", 32'(n), 32'd31);
        step();
        check("s3_led_next", 32'(led), 32'h0004);

        // Period 1 then period 2
        switch = 8'hFF;
        repeat (7) step();
        check("s4_level8", 32'(level), 32'd8);
        check("s4_bps_upd", 32'(CLK_BPS), 32'd0);
        step();
        check("s4_bps_first", 32'(CLK_BPS), 32'd1);
        bad = 0;
        repeat (20) begin
            prev = led;
            step();
            if (CLK_BPS !== 1'b1 || led === prev) bad++;
        end
        check("s4_every_cycle", 32'(bad), 32'd0);
        switch = 8'hFE;
        repeat (7) step();
        check("s4_level7", 32'(level), 32'd7);
        check("s4_bps_upd7", 32'(CLK_BPS), 32'd0);
        wait_tick(20, n);
        check("s4_first_tick7", 32'(n), 32'd2);
        wait_tick(20, n);
        check("s4_gap7", 32'(n), 32'd2);

        // Short glitch ignored, long pulse accepted
        switch = 8'h3E;
        repeat (7) step();
        check("s5_level5", 32'(level), 32'd5);
        wait_tick(40, n);
        check("s5_first_tick", 32'(n), 32'd8);
        step();
        switch = 8'h3F;
        repeat (3) step();
        switch = 8'h3E;
        wait_tick(40, n);
        check("s5_glitch_gap", 32'(n), 32'd4);
        wait_tick(40, n);
        check("s5_gap_after", 32'(n), 32'd8);
        check("s5_level_kept", 32'(level), 32'd5);
        switch = 8'h3F;
        repeat (6) step();
        check("s5_level_pre6", 32'(level), 32'd5);
        step();
        check("s5_level6", 32'(level), 32'd6);

        // Level/period table
        for (int i = 0; i < 7; i++) begin
            switch = lvl_tab[i].sw;
            repeat (7) step();
            check($sformatf("tab%0d_level", i), 32'(level), 32'(lvl_tab[i].exp_level));
            check($sformatf("tab%0d_bps_upd", i), 32'(CLK_BPS), 32'd0);
            if (lvl_tab[i].exp_period > 0) begin
                wait_tick(2 * lvl_tab[i].exp_period + 10, n);
                check($sformatf("tab%0d_first", i), 32'(n), 32'(lvl_tab[i].exp_period));
                wait_tick(2 * lvl_tab[i].exp_period + 10, n);
                check($sformatf("tab%0d_gap", i), 32'(n), 32'(lvl_tab[i].exp_period));
            end else begin
                bad  = 0;
                hold = led;
                repeat (200) begin
                    step();
                    if (CLK_BPS !== 1'b0 || led !== hold) bad++;
                end
                check($sformatf("tab%0d_paused", i), 32'(bad), 32'd0);
            end
        end

        // Async reset in BLINK
        switch = 8'h3F;
        found  = 1'b0;
        for (int i = 0; i < 800 && !found; i++) begin
            step();
            if (led === 16'hFFFF) found = 1'b1;
        end
        check("s6_reach_blink", 32'(found), 32'd1);
        #2;
        rst = 1'b0;
        #1;
        check("s6_async_led", 32'(led), 32'h0000);
        check("s6_async_bps", 32'(CLK_BPS), 32'd0);
        check("s6_async_level", 32'(level), 32'd0);
        switch = 8'h00;
        repeat (3) begin
            step();
            check("s6_rst_led", 32'(led), 32'h0000);
        end
        rst = 1'b1;
        repeat (2) step();
        check("s6_idle_led", 32'(led), 32'h0000);
        run_start("s6");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
